// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and the mul/div FSM states.
package exe_pkg;

  localparam logic [5:0] ALU_SLL   = 6'h00;
  localparam logic [5:0] ALU_SRL   = 6'h02;
  localparam logic [5:0] ALU_SRA   = 6'h03;
  localparam logic [5:0] ALU_SLLV  = 6'h04;
  localparam logic [5:0] ALU_SRLV  = 6'h06;
  localparam logic [5:0] ALU_SRAV  = 6'h07;
  localparam logic [5:0] ALU_LUI   = 6'h0F;
  localparam logic [5:0] ALU_MFHI  = 6'h10;
  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MFLO  = 6'h12;
  localparam logic [5:0] ALU_MTLO  = 6'h13;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;
  localparam logic [5:0] ALU_ADD   = 6'h20;
  localparam logic [5:0] ALU_ADDU  = 6'h21;
  localparam logic [5:0] ALU_SUB   = 6'h22;
  localparam logic [5:0] ALU_SUBU  = 6'h23;
  localparam logic [5:0] ALU_AND   = 6'h24;
  localparam logic [5:0] ALU_OR    = 6'h25;
  localparam logic [5:0] ALU_XOR   = 6'h26;
  localparam logic [5:0] ALU_NOR   = 6'h27;
  localparam logic [5:0] ALU_SLT   = 6'h2A;
  localparam logic [5:0] ALU_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

  // Operations that touch HI/LO and therefore must wait while the unit is busy.
  function automatic logic is_hilo_op(input logic [5:0] op);
    return op inside {ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO,
                      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; the divider is radix-2 restoring,
// one quotient bit per cycle, so DIV_LAT is expected to equal XLEN.
module muldiv_unit
  import exe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_mul,
  input  logic            start_div,
  input  logic            op_signed,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, dvd_q, dvd_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;

  logic             neg_a, neg_b;
  logic [XLEN-1:0]  mag_a, mag_b, rem_nx, quo_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]    rem_sh, diff;

  always_comb begin
    neg_a  = op_signed & src_a[XLEN-1];
    neg_b  = op_signed & src_b[XLEN-1];
    mag_a  = neg_a ? -src_a : src_a;
    mag_b  = neg_b ? -src_b : src_b;
    prod   = {{XLEN{neg_a}}, src_a} * {{XLEN{neg_b}}, src_b};
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
    if (diff[XLEN]) begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = diff[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // NOTE: every _d starts from its held value so no branch can leave a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    case (state_q)
      MD_IDLE: begin
        if (start_mul) begin
          state_d        = MD_MUL;
          cnt_d          = CNT_W'(MUL_LAT - 1);
          {rem_d, quo_d} = prod;
        end else if (start_div) begin
          state_d = MD_DIV;
          cnt_d   = CNT_W'(DIV_LAT - 1);
          rem_d   = '0;
          quo_d   = mag_a;
          dvsr_d  = mag_b;
          dvd_d   = src_a;
          q_neg_d = neg_a ^ neg_b;
          r_neg_d = neg_a;
          div0_d  = (src_b == '0);
        end
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
      end
      MD_MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          hi_d    = rem_q;
          lo_d    = quo_q;
        end
      end
      MD_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          lo_d    = div0_q ? '1    : (q_neg_q ? -quo_nx : quo_nx);
          hi_d    = div0_q ? dvd_q : (r_neg_q ? -rem_nx : rem_nx);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // NOTE: the divider working registers are reset along with HI/LO; they are few and it keeps X out of results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != MD_IDLE);

endmodule

// File: rtl/exe_stage_fwd.sv
// Execute stage: MEM/WB operand forwarding, single-cycle ALU, mul/div unit with HI/LO,
// and the EXE/MEM pipeline register with freeze and bubble insertion.
module exe_stage_fwd
  import exe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR   = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = XLEN
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             valid_ID,
  input  logic             stall_MEM,
  output logic             stall_EXE,
  input  logic [XLEN-1:0]  Operand_A,
  input  logic [XLEN-1:0]  Operand_B,
  input  logic [RADDR-1:0] readRegisterA,
  input  logic [RADDR-1:0] readRegisterB,
  input  logic [15:0]      Imm16,
  input  logic [4:0]       Shamt,
  input  logic             ALUSrc,
  input  logic             ImmZext,
  input  logic [5:0]       ALU_control,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             MemtoReg,
  input  logic             do_writeback,
  input  logic [RADDR-1:0] writeRegister,
  input  logic [XLEN-1:0]  Data_WB,
  input  logic [RADDR-1:0] writeRegister_WB,
  input  logic             do_writeback_WB,
  output logic [XLEN-1:0]  aluResult_PR,
  output logic [XLEN-1:0]  readDataB_PR,
  output logic [RADDR-1:0] writeRegister_PR,
  output logic             MemRead_PR,
  output logic             MemWrite_PR,
  output logic             MemtoReg_PR,
  output logic             do_writeback_PR,
  output logic             muldiv_busy
);

  logic [XLEN-1:0]  alu_result_q, alu_result_d, read_data_b_q, read_data_b_d;
  logic [RADDR-1:0] wr_reg_q, wr_reg_d;
  logic             mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d, do_wb_q, do_wb_d;

  logic [XLEN-1:0]  fwd_a, fwd_b, imm_ext, op_b, alu_res, hi, lo;
  logic             accept, is_mul, is_div;

  // MEM result wins over WB; register 0 is hard-wired and never forwarded.
  always_comb begin
    fwd_a = Operand_A;
    if (do_wb_q && wr_reg_q == readRegisterA && readRegisterA != '0)
      fwd_a = alu_result_q;
    else if (do_writeback_WB && writeRegister_WB == readRegisterA && readRegisterA != '0)
      fwd_a = Data_WB;
    fwd_b = Operand_B;
    if (do_wb_q && wr_reg_q == readRegisterB && readRegisterB != '0)
      fwd_b = alu_result_q;
    else if (do_writeback_WB && writeRegister_WB == readRegisterB && readRegisterB != '0)
      fwd_b = Data_WB;
  end

  assign imm_ext = ImmZext ? {{(XLEN-16){1'b0}}, Imm16} : {{(XLEN-16){Imm16[15]}}, Imm16};
  assign op_b    = ALUSrc ? imm_ext : fwd_b;

  assign is_mul    = (ALU_control == ALU_MULT) || (ALU_control == ALU_MULTU);
  assign is_div    = (ALU_control == ALU_DIV)  || (ALU_control == ALU_DIVU);
  assign stall_EXE = valid_ID & muldiv_busy & is_hilo_op(ALU_control);
  assign accept    = valid_ID & ~stall_EXE & ~stall_MEM;

  always_comb begin
    alu_res = '0;
    case (ALU_control)
      ALU_ADD, ALU_ADDU: alu_res = fwd_a + op_b;
      ALU_SUB, ALU_SUBU: alu_res = fwd_a - op_b;
      ALU_AND:  alu_res = fwd_a & op_b;
      ALU_OR:   alu_res = fwd_a | op_b;
      ALU_XOR:  alu_res = fwd_a ^ op_b;
      ALU_NOR:  alu_res = ~(fwd_a | op_b);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
      ALU_SLL:  alu_res = op_b << Shamt;
      ALU_SRL:  alu_res = op_b >> Shamt;
      ALU_SRA:  alu_res = $signed(op_b) >>> Shamt;
      ALU_SLLV: alu_res = op_b << fwd_a[4:0];
      ALU_SRLV: alu_res = op_b >> fwd_a[4:0];
      ALU_SRAV: alu_res = $signed(op_b) >>> fwd_a[4:0];
      ALU_LUI:  alu_res = XLEN'({Imm16, 16'h0000});
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  muldiv_unit #(
    .XLEN    (XLEN),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_muldiv (
    .clk       (CLK),
    .rst_n     (RESET),
    .start_mul (accept & is_mul),
    .start_div (accept & is_div),
    .op_signed ((ALU_control == ALU_MULT) || (ALU_control == ALU_DIV)),
    .src_a     (fwd_a),
    .src_b     (fwd_b),
    .wr_hi     (accept & (ALU_control == ALU_MTHI)),
    .wr_lo     (accept & (ALU_control == ALU_MTLO)),
    .wr_data   (fwd_a),
    .hi        (hi),
    .lo        (lo),
    .busy      (muldiv_busy)
  );

  // A bubble still captures the data fields; only the control bits are cleared.
  always_comb begin
    alu_result_d  = alu_result_q;
    read_data_b_d = read_data_b_q;
    wr_reg_d      = wr_reg_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    do_wb_d       = do_wb_q;
    if (!stall_MEM) begin
      alu_result_d  = alu_res;
      read_data_b_d = fwd_b;
      wr_reg_d      = writeRegister;
      mem_read_d    = accept & MemRead;
      mem_write_d   = accept & MemWrite;
      mem_to_reg_d  = accept & MemtoReg;
      do_wb_d       = accept & do_writeback & ~(is_mul | is_div);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      alu_result_q  <= '0;
      read_data_b_q <= '0;
      wr_reg_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      do_wb_q       <= 1'b0;
    end else begin
      alu_result_q  <= alu_result_d;
      read_data_b_q <= read_data_b_d;
      wr_reg_q      <= wr_reg_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      do_wb_q       <= do_wb_d;
    end
  end

  assign aluResult_PR     = alu_result_q;
  assign readDataB_PR     = read_data_b_q;
  assign writeRegister_PR = wr_reg_q;
  assign MemRead_PR       = mem_read_q;
  assign MemWrite_PR      = mem_write_q;
  assign MemtoReg_PR      = mem_to_reg_q;
  assign do_writeback_PR  = do_wb_q;

endmodule

// File: tb/tb_exe_stage_fwd.sv
// Directed bench for exe_stage_fwd: forwarding, ALU ops, mul/div timing and results,
// pipeline freeze/bubbles and reset behaviour, all against hand-computed values.
module tb_exe_stage_fwd;
  import exe_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        CLK, RESET, valid_ID, stall_MEM, stall_EXE;
  logic [31:0] Operand_A, Operand_B, Data_WB, aluResult_PR, readDataB_PR;
  logic [4:0]  readRegisterA, readRegisterB, writeRegister, writeRegister_WB, writeRegister_PR;
  logic [15:0] Imm16;
  logic [4:0]  Shamt;
  logic [5:0]  ALU_control;
  logic        ALUSrc, ImmZext, MemRead, MemWrite, MemtoReg, do_writeback, do_writeback_WB;
  logic        MemRead_PR, MemWrite_PR, MemtoReg_PR, do_writeback_PR, muldiv_busy;

  int n_checks = 0;
  int n_fails  = 0;

  exe_stage_fwd #(.XLEN(32), .RADDR(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .valid_ID         (valid_ID),
    .stall_MEM        (stall_MEM),
    .stall_EXE        (stall_EXE),
    .Operand_A        (Operand_A),
    .Operand_B        (Operand_B),
    .readRegisterA    (readRegisterA),
    .readRegisterB    (readRegisterB),
    .Imm16            (Imm16),
    .Shamt            (Shamt),
    .ALUSrc           (ALUSrc),
    .ImmZext          (ImmZext),
    .ALU_control      (ALU_control),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .MemtoReg         (MemtoReg),
    .do_writeback     (do_writeback),
    .writeRegister    (writeRegister),
    .Data_WB          (Data_WB),
    .writeRegister_WB (writeRegister_WB),
    .do_writeback_WB  (do_writeback_WB),
    .aluResult_PR     (aluResult_PR),
    .readDataB_PR     (readDataB_PR),
    .writeRegister_PR (writeRegister_PR),
    .MemRead_PR       (MemRead_PR),
    .MemWrite_PR      (MemWrite_PR),
    .MemtoReg_PR      (MemtoReg_PR),
    .do_writeback_PR  (do_writeback_PR),
    .muldiv_busy      (muldiv_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input int ra, input int rb,
                       input logic [31:0] a, input logic [31:0] b,
                       input int wr, input logic wb);
    valid_ID      = 1'b1;
    ALU_control   = op;
    readRegisterA = 5'(ra);
    readRegisterB = 5'(rb);
    Operand_A     = a;
    Operand_B     = b;
    writeRegister = 5'(wr);
    do_writeback  = wb;
    ALUSrc        = 1'b0;
    ImmZext       = 1'b0;
    Imm16         = 16'h0000;
    Shamt         = 5'd0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] ctl4();
    return {28'h0, MemRead_PR, MemWrite_PR, MemtoReg_PR, do_writeback_PR};
  endfunction

  // Issue a mul/div op, then hold MFLO in ID and measure how long it is stalled.
  task automatic muldiv_check(input string tag, input logic [5:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input int exp_lat);
    int   n;
    logic wb_seen;
    drive(op, 1, 2, a, b, 9, 1'b1);
    tick();
    check({tag, "_busy"}, 32'(muldiv_busy), 32'd1);
    check({tag, "_pr_wb"}, 32'(do_writeback_PR), 32'd0);
    drive(ALU_MFLO, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    n = 0;
    wb_seen = 1'b0;
    while (stall_EXE && n < 200) begin
      n++;
      tick();
      wb_seen |= do_writeback_PR;
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_lat));
    check({tag, "_bubbles"}, 32'(wb_seen), 32'd0);
    tick();
    check({tag, "_lo"}, aluResult_PR, exp_lo);
    drive(ALU_MFHI, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    tick();
    check({tag, "_hi"}, aluResult_PR, exp_hi);
  endtask

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int n;
    vecs = '{
      '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  16'h0000, 32'hF000F000},
      '{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  16'h0000, 32'hFFF0FFF0},
      '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  16'h0000, 32'h0FF00FF0},
      '{ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  16'h0000, 32'h000F000F},
      '{ALU_SUBU, 32'h00000003, 32'h00000005, 5'd0,  16'h0000, 32'hFFFFFFFE},
      '{ALU_ADDU, 32'hFFFFFFFF, 32'h00000002, 5'd0,  16'h0000, 32'h00000001},
      '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  16'h0000, 32'h00000001},
      '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  16'h0000, 32'h00000000},
      '{ALU_SLL,  32'h00000000, 32'h00000001, 5'd31, 16'h0000, 32'h80000000},
      '{ALU_SRA,  32'h00000000, 32'h80000000, 5'd4,  16'h0000, 32'hF8000000},
      '{ALU_SRL,  32'h00000000, 32'h80000000, 5'd4,  16'h0000, 32'h08000000},
      '{ALU_SRLV, 32'h00000008, 32'h0000FF00, 5'd0,  16'h0000, 32'h000000FF},
      '{ALU_SRAV, 32'h00000024, 32'h80000000, 5'd0,  16'h0000, 32'hF8000000},
      '{ALU_LUI,  32'h00000000, 32'h00000000, 5'd0,  16'h1234, 32'h12340000}
    };

    RESET = 1'b0;
    stall_MEM = 1'b0;
    Data_WB = 32'h0;
    writeRegister_WB = 5'd0;
    do_writeback_WB = 1'b0;
    drive(ALU_ADD, 1, 2, 32'd5, 32'd7, 3, 1'b1);
    MemRead = 1'b1;
    MemtoReg = 1'b1;
    tick();
    tick();
    check("rst_alu", aluResult_PR, 32'h0);
    check("rst_rdb", readDataB_PR, 32'h0);
    check("rst_wr", 32'(writeRegister_PR), 32'h0);
    check("rst_ctl", ctl4(), 32'h0);
    check("rst_busy", 32'(muldiv_busy), 32'h0);

    RESET = 1'b1;
    drive(ALU_ADD, 1, 2, 32'd5, 32'd7, 3, 1'b1);
    tick();
    check("add", aluResult_PR, 32'd12);
    check("add_wr", 32'(writeRegister_PR), 32'd3);
    check("add_ctl", ctl4(), 32'h1);

    // r3 sits in MEM while WB also claims r3 with a different value.
    drive(ALU_SUB, 3, 1, 32'd0, 32'd5, 4, 1'b1);
    writeRegister_WB = 5'd3;
    Data_WB = 32'd999;
    do_writeback_WB = 1'b1;
    tick();
    check("fwd_mem", aluResult_PR, 32'd7);
    do_writeback_WB = 1'b0;

    drive(ALU_ADD, 1, 2, 32'd5, 32'd7, 5, 1'b1);
    tick();
    valid_ID = 1'b0;
    tick();
    check("bubble_ctl", ctl4(), 32'h0);
    drive(ALU_SUB, 5, 1, 32'd0, 32'd5, 6, 1'b1);
    writeRegister_WB = 5'd5;
    Data_WB = 32'd100;
    do_writeback_WB = 1'b1;
    tick();
    check("fwd_wb", aluResult_PR, 32'd95);
    do_writeback_WB = 1'b0;

    drive(ALU_ADD, 1, 2, 32'd5, 32'd7, 0, 1'b1);
    tick();
    drive(ALU_ADD, 0, 0, 32'd0, 32'd3, 7, 1'b1);
    writeRegister_WB = 5'd0;
    Data_WB = 32'd50;
    do_writeback_WB = 1'b1;
    tick();
    check("no_fwd_r0", aluResult_PR, 32'd3);
    do_writeback_WB = 1'b0;

    drive(ALU_ADD, 1, 7, 32'd10, 32'd0, 8, 1'b1);
    ALUSrc = 1'b1;
    Imm16 = 16'hFFFF;
    tick();
    check("imm_sext", aluResult_PR, 32'd9);
    check("store_fwd_b", readDataB_PR, 32'd3);
    drive(ALU_OR, 1, 2, 32'd10, 32'd0, 8, 1'b1);
    ALUSrc = 1'b1;
    ImmZext = 1'b1;
    Imm16 = 16'hFFFF;
    tick();
    check("imm_zext", aluResult_PR, 32'h0000FFFF);

    drive(ALU_ADD, 1, 2, 32'd4, 32'd4, 9, 1'b0);
    MemWrite = 1'b1;
    tick();
    check("ctl_pass", ctl4(), 32'h4);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, 1, 2, vecs[i].a, vecs[i].b, 9, 1'b1);
      Shamt = vecs[i].sh;
      Imm16 = vecs[i].imm;
      tick();
      check($sformatf("alu_op%02h", vecs[i].op), aluResult_PR, vecs[i].exp);
    end

    muldiv_check("mult",  ALU_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    muldiv_check("multu", ALU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MUL_LAT);
    muldiv_check("div",   ALU_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);

    // Divide by zero with an unrelated ADD flowing while the unit is busy.
    drive(ALU_DIVU, 1, 2, 32'h1234, 32'h0, 9, 1'b1);
    tick();
    drive(ALU_ADD, 1, 2, 32'd1, 32'd2, 11, 1'b1);
    check("indep_no_stall", 32'(stall_EXE), 32'd0);
    tick();
    check("indep_add", aluResult_PR, 32'd3);
    valid_ID = 1'b0;
    n = 0;
    while (muldiv_busy && n < 200) begin
      n++;
      tick();
    end
    check("divu0_done", 32'(muldiv_busy), 32'd0);
    drive(ALU_MFLO, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    tick();
    check("divu0_lo", aluResult_PR, 32'hFFFFFFFF);
    drive(ALU_MFHI, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    tick();
    check("divu0_hi", aluResult_PR, 32'h00001234);

    // Downstream freeze for three edges while a multiply counts down.
    drive(ALU_MULTU, 1, 2, 32'd3, 32'd4, 9, 1'b1);
    tick();
    drive(ALU_ADD, 1, 2, 32'd5, 32'd7, 3, 1'b1);
    tick();
    check("pre_freeze", aluResult_PR, 32'd12);
    stall_MEM = 1'b1;
    drive(ALU_ADD, 1, 2, 32'd100, 32'd1, 10, 1'b1);
    tick();
    tick();
    tick();
    check("freeze_alu", aluResult_PR, 32'd12);
    check("freeze_wr", 32'(writeRegister_PR), 32'd3);
    check("freeze_mul_done", 32'(muldiv_busy), 32'd0);
    stall_MEM = 1'b0;
    tick();
    check("unfreeze", aluResult_PR, 32'd101);
    drive(ALU_MFLO, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    tick();
    check("freeze_mul_lo", aluResult_PR, 32'd12);

    drive(ALU_MTHI, 1, 0, 32'hCAFE, 32'h0, 0, 1'b0);
    tick();
    stall_MEM = 1'b1;
    drive(ALU_MTHI, 1, 0, 32'h1111, 32'h0, 0, 1'b0);
    tick();
    stall_MEM = 1'b0;
    drive(ALU_MFHI, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    tick();
    check("mthi_held", aluResult_PR, 32'h0000CAFE);
    drive(ALU_MTLO, 1, 0, 32'hBEEF, 32'h0, 0, 1'b0);
    tick();
    drive(ALU_MFLO, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    tick();
    check("mtlo", aluResult_PR, 32'h0000BEEF);

    // Reset in the middle of a divide.
    drive(ALU_DIV, 1, 2, 32'd100, 32'd7, 9, 1'b1);
    tick();
    valid_ID = 1'b0;
    tick();
    tick();
    check("div_running", 32'(muldiv_busy), 32'd1);
    RESET = 1'b0;
    tick();
    check("rst_mid_busy", 32'(muldiv_busy), 32'd0);
    check("rst_mid_alu", aluResult_PR, 32'h0);
    RESET = 1'b1;
    drive(ALU_MFHI, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    tick();
    check("rst_mid_hi", aluResult_PR, 32'h0);
    drive(ALU_MFLO, 0, 0, 32'h0, 32'h0, 10, 1'b1);
    tick();
    check("rst_mid_lo", aluResult_PR, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
